// File: rtl/spi_slave_port.sv
// Single-select SPI slave endpoint clocked by clk: one bit per cycle, parallel rx/tx words.
// Build option SPI_SLAVE_ECHO_EN: transmit the last received word instead of tx_data.
module spi_slave_port #(
    parameter int DATA_WIDTH = 16,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_taken,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    // state | meaning
    // IDLE  | waiting for cs_in; miso_out held low
    // SHIFT | one bit in and one bit out per cycle
    // DONE  | publish rx word (cs_in ignored)
    // HOLD  | wait for cs_in to drop before the next frame
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, HOLD} state_t;

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
    logic [DATA_WIDTH-1:0] rx_data_nxt;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  miso_nxt, tx_taken_nxt, rx_valid_nxt, busy_nxt, frame_err_nxt;
    logic [IDX_W-1:0]      cur_pos, nxt_pos;

    function automatic logic [IDX_W-1:0] idx(input logic [IDX_W-1:0] n);
        return LSB_FIRST ? n : LAST_IDX - n;
    endfunction

`ifdef SPI_SLAVE_ECHO_EN
    logic unused_tx;
    assign unused_tx = ^tx_data;
    assign load_word = rx_data;
`else
    assign load_word = tx_data;
`endif

    assign cur_pos = idx(bit_cnt[IDX_W-1:0]);
    assign nxt_pos = idx(bit_cnt[IDX_W-1:0] + IDX_W'(1));

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        tx_shift_nxt  = tx_shift;
        rx_shift_nxt  = rx_shift;
        rx_data_nxt   = rx_data;
        miso_nxt      = 1'b0;
        tx_taken_nxt  = 1'b0;
        rx_valid_nxt  = 1'b0;
        busy_nxt      = busy;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cs_in) begin
                    tx_shift_nxt = load_word;
                    tx_taken_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    bit_cnt_nxt  = '0;
                    miso_nxt     = load_word[idx('0)];
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_in) begin
                    rx_shift_nxt[cur_pos] = mosi_in;
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = DONE;
                    end else begin
                        miso_nxt    = tx_shift[nxt_pos];
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end else begin
                    // Aborted frame: partial rx_shift is discarded, rx_data stays intact
                    frame_err_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    bit_cnt_nxt   = '0;
                    state_nxt     = IDLE;
                end
            end
            DONE: begin
                rx_data_nxt  = rx_shift;
                rx_valid_nxt = 1'b1;
                state_nxt    = HOLD;
            end
            HOLD: begin
                if (!cs_in) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            miso_out  <= 1'b0;
            tx_taken  <= 1'b0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx_shift  <= tx_shift_nxt;
            rx_shift  <= rx_shift_nxt;
            rx_data   <= rx_data_nxt;
            miso_out  <= miso_nxt;
            tx_taken  <= tx_taken_nxt;
            rx_valid  <= rx_valid_nxt;
            busy      <= busy_nxt;
            frame_err <= frame_err_nxt;
        end
    end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- Single-chip-select SPI slave endpoint; one instance sits on each select/MOSI/MISO lane driven by the team's 3-lane SPI master.
- Consumes select and MOSI from the master and returns MISO, all on the shared system clock (no separate SCLK): one bit per clk cycle.
- Deserialises each received frame into a parallel word for local logic and serialises a locally supplied word back to the master.

Parameters:
- DATA_WIDTH, 16, frame length in bits, and width of tx_data/rx_data.
- LSB_FIRST, 1, 1 = bit 0 on the wire first; 0 = bit DATA_WIDTH-1 first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cs_in  input  1  chip select from master, active-high.
- mosi_in  input  1  serial data from master.
- miso_out  output  1  serial data to master.
- tx_data  input  DATA_WIDTH  word to return; sampled at frame start.
- tx_taken  output  1  one-cycle pulse: tx_data captured.
- rx_data  output  DATA_WIDTH  last complete received word; held until next complete frame.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  high from frame start until return to IDLE.
- frame_err  output  1  one-cycle pulse: cs_in dropped mid-frame.

Behaviour:
- Reset: state = IDLE. miso_out, tx_taken, rx_valid, busy, frame_err, and bit_cnt are 0. rx_data, tx_shift, and rx_shift are all 0. Reset mid-frame aborts immediately with no pulses.
- Bit index idx(n) = n when LSB_FIRST = 1, else DATA_WIDTH-1-n.
- IDLE:
  - If cs_in = 1: tx_shift <= tx_data, tx_taken <= 1, busy <= 1, bit_cnt <= 0, miso_out <= tx_data[idx(0)], state <= SHIFT.
  - Otherwise stay in IDLE with miso_out = 0.
- SHIFT, cs_in = 1:
  - rx_shift[idx(bit_cnt)] <= mosi_in.
  - miso_out <= tx_shift[idx(bit_cnt+1)], or 0 when bit_cnt = DATA_WIDTH-1.
  - bit_cnt <= bit_cnt+1.
  - When bit_cnt = DATA_WIDTH-1: bit_cnt <= 0, state <= DONE.
- SHIFT, cs_in = 0: frame_err <= 1, miso_out <= 0, busy <= 0, bit_cnt <= 0, state <= IDLE. rx_data and rx_valid are untouched.
- DONE: rx_data <= rx_shift, rx_valid <= 1, state <= HOLD. cs_in is ignored for this one cycle.
- HOLD: miso_out = 0. Stay while cs_in = 1. When cs_in = 0: busy <= 0, state <= IDLE. A new frame therefore requires cs_in to deassert for at least one cycle.
- Timing:
  - Each MOSI bit is sampled in the cycle its SHIFT occupies: first sample is 1 cycle after cs_in is seen high, last sample at DATA_WIDTH cycles.
  - rx_valid asserts DATA_WIDTH+2 cycles after the cycle cs_in is first sampled high.
- bit_cnt width is clog2(DATA_WIDTH)+1. No wrap occurs inside a frame.
- tx_data changes after tx_taken do not affect the frame in flight.
- All pulses are exactly one cycle, and only one pulse type fires per cycle.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: the IDLE capture loads tx_shift from rx_data (the last complete received word, 0 after reset) instead of tx_data, so the master reads back its previous frame. tx_taken is still pulsed. tx_data is unused.
- Undefined: behaviour as above, with tx_data as the source.

Test Plan:
- Reset mid-frame (DATA_WIDTH=16, LSB_FIRST=1): raise cs_in, shift 5 bits, assert rst for 1 cycle -> all outputs 0 next cycle, rx_valid never pulses, state IDLE.
- Basic frame (DATA_WIDTH=16, LSB_FIRST=1): tx_data=16'hA5C3; hold cs_in high 20 cycles; drive MOSI with 16'h1234 LSB first.
  - tx_taken pulses 1 cycle after the cycle cs_in is first high.
  - miso_out carries 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles.
  - rx_data = 16'h1234 with rx_valid 18 cycles after cs_in is first sampled high.
  - busy falls 1 cycle after cs_in drops.
- MSB-first (LSB_FIRST=0): MOSI 16'h8001 MSB first, tx_data=16'h8000 -> rx_data=16'h8001; miso_out first bit 1, remaining 15 bits 0.
- Mid-frame abort: drop cs_in after 7 bits -> frame_err pulses once, rx_valid stays 0, rx_data keeps its previous value, next full frame completes normally.
- Back-to-back frames: hold cs_in high 3 cycles past DONE, then low 1 cycle, then high again -> exactly one rx_valid per frame; the second frame captures the new tx_data (16'h00FF).
- SPI_SLAVE_ECHO_EN defined: frame 1 sends 16'hBEEF, frame 2 sends 16'h0000 -> miso_out in frame 2 serialises 16'hBEEF; frame 1 returns 16'h0000.
